// File: rtl/persiana_actuador.sv
// Blind motor actuator: turns the closed/half/open command into timed up/down motor drive
// with dead time before every start or reversal, limit-switch recalibration and a sticky fault.
module persiana_actuador #(
    parameter int POS_W     = 8,
    parameter int POS_MAX   = 200,
    parameter int POS_MEDIO = 100,
    parameter int DIV       = 1000,
    parameter int DEAD      = 16
) (
    input  logic             reloj,
    input  logic             reset,
    input  logic [1:0]       P,
    input  logic             fin_arriba,
    input  logic             fin_abajo,
    output logic             motor_sube,
    output logic             motor_baja,
    output logic [POS_W-1:0] posicion,
    output logic             en_movimiento,
    output logic             en_destino,
    output logic             falla
);

    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int MUE_W = (DEAD > 1) ? $clog2(DEAD) : 1;
    localparam logic [PRE_W-1:0] PRE_ULT = PRE_W'(DIV - 1);
    localparam logic [MUE_W-1:0] MUE_ULT = MUE_W'(DEAD - 1);
    localparam logic [POS_W-1:0] L_MAX   = POS_W'(POS_MAX);
    localparam logic [POS_W-1:0] L_MEDIO = POS_W'(POS_MEDIO);

    typedef enum logic [1:0] {
        REPOSO = 2'd0,
        PAUSA  = 2'd1,
        SUBE   = 2'd2,
        BAJA   = 2'd3
    } estado_t;

    estado_t          r_estado,   w_estado;
    logic [POS_W-1:0] r_objetivo, w_objetivo;
    logic [POS_W-1:0] r_posicion, w_posicion;
    logic [PRE_W-1:0] r_presc,    w_presc;
    logic [MUE_W-1:0] r_muerto,   w_muerto;
    logic             r_dir,      w_dir;      // 1 = up
    logic             r_falla,    w_falla;

    logic             w_mayor, w_menor, w_igual;
    logic [POS_W-1:0] w_pos_mas, w_pos_menos;

    assign w_mayor     = (r_objetivo > r_posicion);
    assign w_menor     = (r_objetivo < r_posicion);
    assign w_igual     = (r_objetivo == r_posicion);
    assign w_pos_mas   = (r_posicion >= L_MAX) ? L_MAX : r_posicion + 1'b1;
    assign w_pos_menos = (r_posicion == '0) ? '0 : r_posicion - 1'b1;

    always_comb begin
        // NOTE: every next-state variable gets its hold value first so no path infers a latch.
        w_estado   = r_estado;
        w_objetivo = r_objetivo;
        w_posicion = r_posicion;
        w_presc    = r_presc;
        w_muerto   = r_muerto;
        w_dir      = r_dir;
        w_falla    = r_falla;

        case (P)
            2'b00:   w_objetivo = '0;
            2'b01:   w_objetivo = L_MEDIO;
            2'b10:   w_objetivo = L_MAX;
            default: w_objetivo = r_objetivo;
        endcase

        if (fin_arriba && fin_abajo) begin
            w_falla  = 1'b1;
            w_estado = REPOSO;
        end else begin
            case (r_estado)
                REPOSO: begin
                    if (!r_falla && !w_igual) begin
                        w_estado = PAUSA;
                        w_dir    = w_mayor;
                        w_muerto = '0;
                    end
                end
                PAUSA: begin
                    if (w_igual) begin
                        w_estado = REPOSO;
                    end else if (r_dir != w_mayor) begin
                        w_dir    = w_mayor;
                        w_muerto = '0;
                    end else if (r_muerto == MUE_ULT) begin
                        // Partial steps from an earlier run are discarded on every start.
                        w_estado = r_dir ? SUBE : BAJA;
                        w_presc  = '0;
                    end else begin
                        w_muerto = r_muerto + 1'b1;
                    end
                end
                SUBE: begin
                    if (fin_arriba) begin
                        w_posicion = L_MAX;
                        w_estado   = REPOSO;
                    end else if (w_menor) begin
                        w_estado = PAUSA;
                        w_dir    = 1'b0;
                        w_muerto = '0;
                    end else if (w_igual) begin
                        w_estado = REPOSO;
                    end else if (r_presc == PRE_ULT) begin
                        w_presc    = '0;
                        w_posicion = w_pos_mas;
                        if (w_pos_mas == r_objetivo)
                            w_estado = REPOSO;
                    end else begin
                        w_presc = r_presc + 1'b1;
                    end
                end
                BAJA: begin
                    if (fin_abajo) begin
                        w_posicion = '0;
                        w_estado   = REPOSO;
                    end else if (w_mayor) begin
                        w_estado = PAUSA;
                        w_dir    = 1'b1;
                        w_muerto = '0;
                    end else if (w_igual) begin
                        w_estado = REPOSO;
                    end else if (r_presc == PRE_ULT) begin
                        w_presc    = '0;
                        w_posicion = w_pos_menos;
                        if (w_pos_menos == r_objetivo)
                            w_estado = REPOSO;
                    end else begin
                        w_presc = r_presc + 1'b1;
                    end
                end
                default: w_estado = REPOSO;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge reloj or negedge reset) begin
        if (!reset) begin
            r_estado   <= REPOSO;
            r_objetivo <= '0;
            r_posicion <= '0;
            r_presc    <= '0;
            r_muerto   <= '0;
            r_dir      <= 1'b0;
            r_falla    <= 1'b0;
        end else begin
            r_estado   <= w_estado;
            r_objetivo <= w_objetivo;
            r_posicion <= w_posicion;
            r_presc    <= w_presc;
            r_muerto   <= w_muerto;
            r_dir      <= w_dir;
            r_falla    <= w_falla;
        end
    end

    assign motor_sube    = (r_estado == SUBE);
    assign motor_baja    = (r_estado == BAJA);
    assign en_movimiento = (r_estado == SUBE) || (r_estado == BAJA);
    assign en_destino    = (r_estado == REPOSO) && w_igual;
    assign posicion      = r_posicion;
    assign falla         = r_falla;

endmodule

// File: tb/tb_persiana_actuador.sv
// Bench for persiana_actuador: directed scenarios plus random command/limit-switch traffic,
// all checked every cycle against a cycle-level behavioural model of the blind.
module tb_persiana_actuador;

    localparam int POS_W = 8;
    localparam int MAXP  = 10;
    localparam int MEDIO = 5;
    localparam int DIVT  = 4;
    localparam int DEADT = 2;

    localparam int M_IDLE = 0;
    localparam int M_WAIT = 1;
    localparam int M_UP   = 2;
    localparam int M_DOWN = 3;

    logic             reloj = 1'b0;
    logic             reset;
    logic [1:0]       P;
    logic             fin_arriba, fin_abajo;
    logic             motor_sube, motor_baja, en_movimiento, en_destino, falla;
    logic [POS_W-1:0] posicion;

    int n_err = 0;
    int n_chk = 0;

    // Behavioural model of the blind
    int m_mode, m_target, m_pos, m_wait, m_ticks;
    bit m_up, m_fault;

    persiana_actuador #(
        .POS_W(POS_W), .POS_MAX(MAXP), .POS_MEDIO(MEDIO), .DIV(DIVT), .DEAD(DEADT)
    ) dut (
        .reloj(reloj), .reset(reset), .P(P),
        .fin_arriba(fin_arriba), .fin_abajo(fin_abajo),
        .motor_sube(motor_sube), .motor_baja(motor_baja),
        .posicion(posicion), .en_movimiento(en_movimiento),
        .en_destino(en_destino), .falla(falla)
    );

    always #5 reloj = ~reloj;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_target = 0; m_pos = 0;
        m_wait = 0; m_ticks = 0; m_up = 0; m_fault = 0;
    endtask

    task automatic model_step(input int p, input bit fa, input bit fb);
        int nt;
        nt = (p == 0) ? 0 : (p == 1) ? MEDIO : (p == 2) ? MAXP : m_target;
        if (fa && fb) begin
            m_fault = 1;
            m_mode  = M_IDLE;
        end else begin
            case (m_mode)
                M_IDLE: if (!m_fault && m_target != m_pos) begin
                    m_mode = M_WAIT; m_up = (m_target > m_pos); m_wait = DEADT;
                end
                M_WAIT: begin
                    if (m_target == m_pos) m_mode = M_IDLE;
                    else if (m_up != (m_target > m_pos)) begin
                        m_up = (m_target > m_pos); m_wait = DEADT;
                    end else begin
                        m_wait--;
                        if (m_wait == 0) begin
                            m_mode  = m_up ? M_UP : M_DOWN;
                            m_ticks = 0;
                        end
                    end
                end
                M_UP: begin
                    if (fa) begin m_pos = MAXP; m_mode = M_IDLE; end
                    else if (m_target < m_pos) begin m_mode = M_WAIT; m_up = 0; m_wait = DEADT; end
                    else if (m_target == m_pos) m_mode = M_IDLE;
                    else begin
                        m_ticks++;
                        if (m_ticks % DIVT == 0) begin
                            m_pos = (m_pos + 1 > MAXP) ? MAXP : m_pos + 1;
                            if (m_pos == m_target) m_mode = M_IDLE;
                        end
                    end
                end
                default: begin
                    if (fb) begin m_pos = 0; m_mode = M_IDLE; end
                    else if (m_target > m_pos) begin m_mode = M_WAIT; m_up = 1; m_wait = DEADT; end
                    else if (m_target == m_pos) m_mode = M_IDLE;
                    else begin
                        m_ticks++;
                        if (m_ticks % DIVT == 0) begin
                            m_pos = (m_pos - 1 < 0) ? 0 : m_pos - 1;
                            if (m_pos == m_target) m_mode = M_IDLE;
                        end
                    end
                end
            endcase
        end
        m_target = nt;
    endtask

    task automatic compare_all();
        check("sube",  motor_sube,    m_mode == M_UP);
        check("baja",  motor_baja,    m_mode == M_DOWN);
        check("pos",   posicion,      m_pos);
        check("mov",   en_movimiento, (m_mode == M_UP) || (m_mode == M_DOWN));
        check("dest",  en_destino,    (m_mode == M_IDLE) && (m_pos == m_target));
        check("falla", falla,         m_fault);
        check("ambos", motor_sube & motor_baja, 0);
    endtask

    // Called at a falling edge; returns at the next falling edge after checking.
    task automatic tick(input logic [1:0] p, input logic fa, input logic fb);
        P = p; fin_arriba = fa; fin_abajo = fb;
        @(posedge reloj);
        model_step(p, fa, fb);
        @(negedge reloj);
        compare_all();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(posedge reloj);
        @(negedge reloj);
        reset = 1'b1;
    endtask

    function automatic logic pick(input int sel);
        case (sel)
            0:       return motor_sube;
            1:       return motor_baja;
            default: return en_destino;
        endcase
    endfunction

    task automatic ticks_until(input logic [1:0] p, input int sel, input logic level,
                               input int budget, output int n);
        n = 0;
        while (n < budget) begin
            tick(p, 1'b0, 1'b0);
            n++;
            if (pick(sel) == level) return;
        end
        check("timeout", pick(sel), level);
    endtask

    task automatic ticks_until_pos(input logic [1:0] p, input int target, input int budget);
        for (int k = 0; k < budget; k++) begin
            tick(p, 1'b0, 1'b0);
            if (posicion == target) break;
        end
        check("alcanza_pos", posicion, target);
    endtask

    initial begin
        int n;
        logic [1:0] rp;
        logic fa, fb;

        P = 2'b00; fin_arriba = 1'b0; fin_abajo = 1'b0; reset = 1'b0;
        @(negedge reloj);
        model_reset();
        compare_all();
        check("rst_dest", en_destino, 1);
        check("rst_pos", posicion, 0);
        reset = 1'b1;

        // Idle at closed
        repeat (10) tick(2'b00, 1'b0, 1'b0);
        check("idle_dest", en_destino, 1);
        check("idle_mov", en_movimiento, 0);

        // Open: dead time then 40 cycles of upward motion
        ticks_until(2'b10, 0, 1'b1, 20, n);
        check("arranque_sube", n, 4);
        ticks_until(2'b10, 0, 1'b0, 100, n);
        check("carrera_sube", n, 40);
        check("pos_abierta", posicion, MAXP);
        check("dest_abierta", en_destino, 1);

        // Half: dead time then 20 cycles down
        ticks_until(2'b01, 1, 1'b1, 20, n);
        check("arranque_baja", n, 4);
        ticks_until(2'b01, 1, 1'b0, 100, n);
        check("carrera_baja", n, 20);
        check("pos_medio", posicion, MEDIO);

        // Reversal while climbing at 3
        ticks_until(2'b00, 2, 1'b1, 200, n);
        ticks_until_pos(2'b10, 3, 100);
        tick(2'b00, 1'b0, 1'b0);
        check("rev_sube_aun", motor_sube, 1);
        tick(2'b00, 1'b0, 1'b0);
        check("rev_sube_off", motor_sube, 0);
        ticks_until(2'b00, 1, 1'b1, 10, n);
        check("rev_muerto", n, 2);
        ticks_until(2'b00, 2, 1'b1, 100, n);

        // Upper limit switch recalibration at 7
        ticks_until(2'b01, 2, 1'b1, 200, n);
        ticks_until_pos(2'b10, 7, 100);
        tick(2'b10, 1'b1, 1'b0);
        check("fin_pos", posicion, MAXP);
        check("fin_motor", motor_sube, 0);
        check("fin_dest", en_destino, 1);

        // Double limit fault during BAJA
        ticks_until(2'b00, 1, 1'b1, 20, n);
        tick(2'b00, 1'b1, 1'b1);
        check("falla_set", falla, 1);
        check("falla_motor", motor_baja, 0);
        repeat (30) tick(2'b10, 1'b0, 1'b0);
        check("falla_quieto", en_movimiento, 0);
        do_reset();
        check("falla_clr", falla, 0);

        // Invalid command holds the target
        ticks_until(2'b01, 2, 1'b1, 200, n);
        repeat (20) tick(2'b11, 1'b0, 1'b0);
        check("p11_pos", posicion, MEDIO);
        check("p11_mov", en_movimiento, 0);
        check("p11_dest", en_destino, 1);

        // Random traffic
        rp = 2'b00;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 24) == 0) rp = 2'($urandom_range(0, 3));
            fa = ($urandom_range(0, 39) == 0);
            fb = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 499) == 0) begin fa = 1'b1; fb = 1'b1; end
            tick(rp, fa, fb);
            if (falla && $urandom_range(0, 29) == 0) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/persiana_actuador.md
Name: persiana_actuador

Overview:
- Executes the 2-bit blind-position command P produced by the automatic-blind Moore FSM: closed/half/open.
- Drives the blind motor up or down with a timed position estimate, dead time on start/reversal and limit-switch recalibration.
- Reports current position, motion and arrival status.
- Sits between the command FSM and the motor driver pins.

Parameters:
- POS_W, 8, width of the position estimate.
- POS_MAX, 200, position count when fully open (must be < 2^POS_W).
- POS_MEDIO, 100, position count for half-open (0 < POS_MEDIO < POS_MAX).
- DIV, 1000, reloj cycles per one position step while moving (≥2).
- DEAD, 16, motor-off cycles before any start or reversal (≥1).

Ports:
- reloj  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- P  input  2  commanded level: 00 closed, 01 half, 10 open, 11 invalid.
- fin_arriba  input  1  upper limit switch, 1 = reached (already synchronous).
- fin_abajo  input  1  lower limit switch, 1 = reached (already synchronous).
- motor_sube  output  1  drive motor upward.
- motor_baja  output  1  drive motor downward.
- posicion  output  POS_W  current position estimate.
- en_movimiento  output  1  state is SUBE or BAJA.
- en_destino  output  1  state is REPOSO and posicion == objetivo.
- falla  output  1  sticky fault flag.

Behaviour:
- Reset (reset=0, async): state REPOSO, objetivo=0, posicion=0, prescaler=0, dead counter=0, dir=0, falla=0.
  - All outputs 0 except en_destino=1.
- objetivo register, updated every edge:
  - P=00 → 0; P=01 → POS_MEDIO; P=10 → POS_MAX.
  - P=11 → hold previous objetivo.
- Moore outputs decode from the state register only:
  - motor_sube=1 only in SUBE; motor_baja=1 only in BAJA.
  - Never both 1.
- REPOSO:
  - objetivo>posicion → PAUSA, dir=up.
  - objetivo<posicion → PAUSA, dir=down.
  - Otherwise stay.
- PAUSA:
  - Motor off for exactly DEAD cycles.
  - Then: dir=up and objetivo>posicion → SUBE; dir=down and objetivo<posicion → BAJA.
  - If objetivo changed so that dir is now wrong → restart PAUSA with corrected dir (dead time restarts).
  - If objetivo==posicion → REPOSO.
- SUBE:
  - Prescaler counts 0..DIV-1. On the edge where prescaler==DIV-1: posicion+1 (saturate at POS_MAX) and prescaler→0.
  - If the new posicion==objetivo, go to REPOSO on that same edge.
  - objetivo<posicion → PAUSA, dir=down (reversal always passes through dead time).
  - objetivo==posicion mid-step → REPOSO.
  - fin_arriba=1 → posicion=POS_MAX, REPOSO.
- BAJA: symmetric with SUBE. Decrement, saturate at 0; fin_abajo=1 → posicion=0, REPOSO.
- Prescaler clears on every entry to SUBE or BAJA; partial steps are discarded.
- Limit switches are ignored in REPOSO/PAUSA and when moving away from them.
- Fault handling:
  - fin_arriba & fin_abajo both 1 in any state → falla=1, state REPOSO, motors off.
  - falla holds until reset; while falla=1 no transition leaves REPOSO.
- posicion never exceeds POS_MAX and never wraps.

Test Plan (DIV=4, DEAD=2, POS_MAX=10, POS_MEDIO=5):
- Reset release, P=00 held → REPOSO, posicion=0, en_destino=1, motors 0 indefinitely.
- P 00→10 at edge n → PAUSA from n+1, motor_sube=1 from n+3; posicion increments every 4 cycles; at 10, motor_sube=0 and en_destino=1 (40 cycles after motor start).
- At posicion=10, P=01 → 2 dead cycles, then motor_baja for 20 cycles; stops at posicion=5.
- While SUBE at posicion=3 toward 10, P=00 → motor_sube drops next edge, 2 cycles both motors 0, then motor_baja; never both motors 1.
- Moving up from 5 toward 10, fin_arriba=1 at posicion=7 → posicion=10, REPOSO, motor off the next cycle.
- fin_arriba=fin_abajo=1 for 1 cycle during BAJA → falla=1, motors 0.
  - A later P change produces no motion.
  - reset=0 then 1 clears falla.
- P=11 while at posicion=5 → objetivo held, no motion.
